// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types and instruction constants
package cpu_pkg;
  typedef enum logic [1:0] {FILL, RUN, HALT} fetch_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] HALT_INSTR = 32'h1400_0000;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 21;
  localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: enabled register with synchronous active-low reset
module pc_reg #(
  parameter int W = 64,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (!reset_n) q <= RESET_VAL;
    else if (en) q <= d;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC sequencing, IF/ID register and FILL/RUN/HALT control
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              flush,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_instr,
  output logic [10:0]       if_opcode,
  output logic              if_valid,
  output logic              halted,
  output logic [31:0]       fetch_count
);
  fetch_state_t state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_d;
  logic halt_st, bubble, load, pc_en;
  assign halt_st = state == HALT;
  assign bubble = br_taken | (flush & ~halt_st);
  assign load = ~halt_st & ~br_taken & ~flush & ~stall;
  assign pc_en = br_taken | (~halt_st & ~stall);
  assign pc_d = br_taken ? (br_target & ~ADDR_W'(3)) : pc + ADDR_W'(INSTR_BYTES);
  pc_reg #(.W(ADDR_W), .RESET_VAL(RESET_PC)) u_pc (
    .clk(clk), .reset_n(reset_n), .en(pc_en), .d(pc_d), .q(pc)
  );
  assign imem_addr = pc;
  assign halted = halt_st;
  assign if_opcode = if_instr[OPCODE_MSB:OPCODE_LSB];
  always_comb
    state_nxt = br_taken ? RUN :
                (load && imem_rdata == HALT_INSTR) ? HALT :
                halt_st ? HALT : RUN;
  always_ff @(posedge clk)
    if (!reset_n) state <= FILL;
    else state <= state_nxt;
  always_ff @(posedge clk)
    if (!reset_n) begin
      if_pc <= RESET_PC;
      if_instr <= NOP_INSTR;
      if_valid <= 1'b0;
      fetch_count <= '0;
    end else if (bubble) begin
      if_instr <= NOP_INSTR;
      if_valid <= 1'b0;
    end else if (load) begin
      if_pc <= pc;
      if_instr <= imem_rdata;
      if_valid <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and randomized checks of instr_fetch against a behavioural model
module tb_instr_fetch;
  localparam logic [31:0] HALT_W = 32'h1400_0000;
  localparam logic [31:0] K = 32'hA5A5_1234;
  logic clk = 0, reset_n, stall, flush, br_taken;
  logic [63:0] imem_addr, br_target, if_pc, halt_addr;
  logic [31:0] imem_rdata, if_instr, fetch_count;
  logic [10:0] if_opcode;
  logic if_valid, halted;
  int total = 0, bad = 0;
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_instr, m_cnt;
  logic m_valid, m_halt;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush), .br_taken(br_taken), .br_target(br_target),
    .if_pc(if_pc), .if_instr(if_instr), .if_opcode(if_opcode), .if_valid(if_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a == halt_addr) ? HALT_W : (a[31:0] ^ K);
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic tick();
    logic [31:0] ins;
    ins = mem_word(m_pc);
    if (!reset_n) begin
      m_pc = 0; m_ifpc = 0; m_instr = 0; m_valid = 0; m_halt = 0; m_cnt = 0;
    end else if (br_taken) begin
      m_pc = {br_target[63:2], 2'b00}; m_instr = 0; m_valid = 0; m_halt = 0;
    end else if (!m_halt) begin
      if (flush) begin
        m_instr = 0; m_valid = 0;
      end else if (!stall) begin
        m_ifpc = m_pc; m_instr = ins; m_valid = 1; m_cnt = m_cnt + 1; m_halt = (ins == HALT_W);
      end
      if (!stall) m_pc = m_pc + 64'd4;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    stall = 0; flush = 0; br_taken = 0; br_target = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; stall = 1; flush = 1; br_taken = 1; br_target = 64'h1234;
    tick(); tick();
    total++;
    if (imem_addr !== 0 || if_pc !== 0 || if_instr !== 0 || if_valid !== 0 || halted !== 0 || fetch_count !== 0) begin
      bad++; $display("FAIL reset: addr=%h pc=%h instr=%h v=%b h=%b cnt=%0d required all zero", imem_addr, if_pc, if_instr, if_valid, halted, fetch_count);
    end
  endtask

  task automatic test_free_run();
    logic [63:0] exp_addr [4] = '{64'h0, 64'h4, 64'h8, 64'hC};
    logic exp_v [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    idle(); reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      total++;
      if (imem_addr !== exp_addr[i] || if_valid !== exp_v[i]) begin
        bad++; $display("FAIL free_run[%0d]: addr=%h v=%b required addr=%h v=%b", i, imem_addr, if_valid, exp_addr[i], exp_v[i]);
      end
    end
    total++;
    if (fetch_count !== 32'd3) begin bad++; $display("FAIL free_run_count: got %0d required 3", fetch_count); end
  endtask

  task automatic test_stall();
    reset_n = 0; tick(); reset_n = 1; idle(); tick(); tick();
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (imem_addr !== 64'h8 || if_pc !== 64'h4 || fetch_count !== 32'd2) begin
        bad++; $display("FAIL stall[%0d]: addr=%h if_pc=%h cnt=%0d required 8 4 2", i, imem_addr, if_pc, fetch_count);
      end
    end
  endtask

  task automatic test_branch_stall();
    stall = 1; br_taken = 1; br_target = 64'h102;
    tick();
    total++;
    if (imem_addr !== 64'h100 || if_valid !== 0 || if_instr !== 0) begin
      bad++; $display("FAIL br_stall: addr=%h v=%b instr=%h required 100 0 0", imem_addr, if_valid, if_instr);
    end
    idle(); tick();
    total++;
    if (if_pc !== 64'h100 || if_valid !== 1 || if_instr !== (32'h100 ^ K) || if_opcode !== if_instr[31:21]) begin
      bad++; $display("FAIL br_target_load: if_pc=%h v=%b instr=%h required 100 1 %h", if_pc, if_valid, if_instr, 32'h100 ^ K);
    end
  endtask

  task automatic test_halt();
    logic [31:0] cnt0;
    halt_addr = 64'h20;
    br_taken = 1; br_target = 64'h20; tick(); idle();
    cnt0 = fetch_count;
    tick();
    total++;
    if (halted !== 1 || imem_addr !== 64'h24 || if_instr !== HALT_W || if_opcode !== 11'h0A0 || fetch_count !== cnt0 + 1) begin
      bad++; $display("FAIL halt_enter: h=%b addr=%h instr=%h op=%h required 1 24 %h 0a0", halted, imem_addr, if_instr, if_opcode, HALT_W);
    end
    for (int i = 0; i < 5; i++) begin
      flush = i[0]; stall = i[1];
      tick();
      total++;
      if (halted !== 1 || imem_addr !== 64'h24 || if_valid !== 1 || if_pc !== 64'h20 || fetch_count !== cnt0 + 1) begin
        bad++; $display("FAIL halt_freeze[%0d]: h=%b addr=%h v=%b if_pc=%h cnt=%0d", i, halted, imem_addr, if_valid, if_pc, fetch_count);
      end
    end
  endtask

  task automatic test_halt_recover();
    idle(); br_taken = 1; br_target = 64'h40; tick(); idle();
    total++;
    if (halted !== 0 || imem_addr !== 64'h40 || if_valid !== 0) begin
      bad++; $display("FAIL halt_recover: h=%b addr=%h v=%b required 0 40 0", halted, imem_addr, if_valid);
    end
    tick();
    total++;
    if (if_pc !== 64'h40 || if_valid !== 1 || imem_addr !== 64'h44 || halted !== 0) begin
      bad++; $display("FAIL resume: if_pc=%h v=%b addr=%h h=%b required 40 1 44 0", if_pc, if_valid, imem_addr, halted);
    end
  endtask

  task automatic test_random();
    halt_addr = 64'h80;
    for (int i = 0; i < 400; i++) begin
      br_taken = ($urandom_range(0, 9) == 0);
      br_target = 64'($urandom_range(0, 255));
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 5) == 0);
      tick();
      total++;
      if ({imem_addr, if_pc, if_instr, if_valid, halted, fetch_count} !== {m_pc, m_ifpc, m_instr, m_valid, m_halt, m_cnt}
          || if_opcode !== m_instr[31:21]) begin
        bad++; $display("FAIL random[%0d]: addr=%h if_pc=%h instr=%h v=%b h=%b cnt=%0d required %h %h %h %b %b %0d",
          i, imem_addr, if_pc, if_instr, if_valid, halted, fetch_count, m_pc, m_ifpc, m_instr, m_valid, m_halt, m_cnt);
      end
    end
  endtask

  task automatic test_mid_reset();
    halt_addr = '1;
    idle(); reset_n = 0; tick(); reset_n = 1;
    for (int i = 0; i < 12; i++) tick();
    total++;
    if (imem_addr !== 64'h30 || fetch_count !== 32'd12) begin
      bad++; $display("FAIL pre_reset: addr=%h cnt=%0d required 30 12", imem_addr, fetch_count);
    end
    reset_n = 0; br_taken = 1; br_target = 64'h80; tick(); idle(); reset_n = 1;
    total++;
    if (imem_addr !== 0 || fetch_count !== 0 || if_valid !== 0 || if_pc !== 0 || halted !== 0) begin
      bad++; $display("FAIL mid_reset: addr=%h cnt=%0d v=%b if_pc=%h h=%b required zeros", imem_addr, fetch_count, if_valid, if_pc, halted);
    end
    tick();
    total++;
    if (if_valid !== 1 || if_pc !== 0 || if_instr !== K || imem_addr !== 64'h4 || fetch_count !== 1) begin
      bad++; $display("FAIL refill: v=%b if_pc=%h instr=%h addr=%h cnt=%0d required 1 0 %h 4 1", if_valid, if_pc, if_instr, imem_addr, fetch_count, K);
    end
  endtask

  initial begin
    halt_addr = '1;
    idle();
    test_reset();
    test_free_run();
    test_stall();
    test_branch_stall();
    test_halt();
    test_halt_recover();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
